// File: rtl/alu_seq_if.sv
// Operand/request and result/flag bundle between the CPU controller and alu_seq.
// The master side issues requests; the slave side (the ALU) returns registered results.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;

    modport master (
        output start, alu_ctrl, src1, src2,
        input  busy, done, result, zero, cout, overflow
    );

    modport slave (
        input  start, alu_ctrl, src1, src2,
        output busy, done, result, zero, cout, overflow
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle AND/OR/ADD/SUB/SLT/NOR and a WIDTH-cycle
// LSB-first shift-add unsigned multiply, with a start/done handshake.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned PW  = 2 * WIDTH;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] op_res;
    logic             op_cout;
    logic             op_ovf;
    logic [PW-1:0]    acc_step;

    // Shared adders; SUB and SLT both use A + ~B + 1 so SLT stays correct across overflow.
    assign sum_w   = {1'b0, bus.src1} + {1'b0, bus.src2};
    assign diff_w  = {1'b0, bus.src1} + {1'b0, ~bus.src2} + (WIDTH + 1)'(1);
    assign add_ovf = (bus.src1[MSB] == bus.src2[MSB]) && (sum_w[MSB] != bus.src1[MSB]);
    assign sub_ovf = (bus.src1[MSB] != bus.src2[MSB]) && (diff_w[MSB] != bus.src1[MSB]);
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Single-cycle op decode; illegal codes fall through to all-zero result and flags.
    always_comb begin
        op_res  = '0;
        op_cout = 1'b0;
        op_ovf  = 1'b0;
        case (bus.alu_ctrl)
            OP_AND: op_res = bus.src1 & bus.src2;
            OP_OR:  op_res = bus.src1 | bus.src2;
            OP_NOR: op_res = ~(bus.src1 | bus.src2);
            OP_ADD: begin
                op_res  = sum_w[MSB:0];
                op_cout = sum_w[WIDTH];
                op_ovf  = add_ovf;
            end
            OP_SUB: begin
                op_res  = diff_w[MSB:0];
                op_cout = diff_w[WIDTH];
                op_ovf  = sub_ovf;
            end
            OP_SLT: op_res = WIDTH'(diff_w[MSB] ^ sub_ovf);
            default: ;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.alu_ctrl == OP_MUL) begin
                        mcand_d  = PW'(bus.src1);
                        mplier_d = bus.src2;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(WIDTH);
                        busy_d   = 1'b1;
                        state_d  = S_MUL;
                    end else begin
                        result_d = op_res;
                        zero_d   = (op_res == '0);
                        cout_d   = op_cout;
                        ovf_d    = op_ovf;
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = acc_step[MSB:0];
                    zero_d   = (acc_step[MSB:0] == '0);
                    ovf_d    = |acc_step[PW-1:WIDTH];
                    cout_d   = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized plus directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
    localparam int unsigned WIDTH = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [WIDTH-1:0] exp_res  = '0;
    logic             exp_zero = 1'b1;
    logic             exp_cout = 1'b0;
    logic             exp_ovf  = 1'b0;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: signed/unsigned arithmetic on 64-bit values, no bit-level datapath.
    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic co, output logic ov);
        logic [63:0] w;
        longint      sa, sb, sr;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        r  = '0;
        co = 1'b0;
        ov = 1'b0;
        case (c)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_NOR: r = ~(a | b);
            OP_ADD: begin
                w  = 64'(a) + 64'(b);
                r  = w[31:0];
                co = w[32];
                sr = sa + sb;
                ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            OP_SUB: begin
                w  = 64'(a) - 64'(b);
                r  = w[31:0];
                co = (a >= b);
                sr = sa - sb;
                ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            OP_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
            OP_MUL: begin
                w  = 64'(a) * 64'(b);
                r  = w[31:0];
                ov = (w[63:32] != 0);
            end
            default: ;
        endcase
    endfunction

    // Issue one request; poke=1 pulses a SUB start midway through a MUL.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input bit poke);
        logic [31:0] r;
        logic        co, ov, held_ok;
        int          lat;
        model(c, a, b, r, co, ov);
        @(negedge clk);
        bus.start = 1'b1; bus.alu_ctrl = c; bus.src1 = a; bus.src2 = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.src1 = $urandom; bus.src2 = $urandom;
        lat = 0;
        held_ok = 1'b1;
        while (!bus.done && lat < int'(WIDTH) + 8) begin
            if (bus.busy !== 1'b1 || bus.result !== exp_res) held_ok = 1'b0;
            if (poke && lat == 5) begin
                bus.start = 1'b1; bus.alu_ctrl = OP_SUB; bus.src1 = 32'd100; bus.src2 = 32'd1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), (c == OP_MUL) ? 64'(WIDTH) : 64'd0);
        if (c == OP_MUL) check({tag, "_hold"}, 64'(held_ok), 64'd1);
        check({tag, "_result"}, 64'(bus.result), 64'(r));
        check({tag, "_flags"}, {61'd0, bus.zero, bus.cout, bus.overflow},
              {61'd0, (r == 0), co, ov});
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        exp_res = r; exp_zero = (r == 0); exp_cout = co; exp_ovf = ov;
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(bus.done), 64'd0);
    endtask

    logic [3:0]  ops [8] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL, 4'b1111};
    logic [3:0]  bad [9] = '{4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
    logic [31:0] corner [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0001_0000};

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        int         dones;
        logic [3:0] c;
        logic [31:0] a, b;
        bus.start = 1'b0; bus.alu_ctrl = '0; bus.src1 = '0; bus.src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {58'd0, bus.busy, bus.done, bus.zero, bus.cout, bus.overflow, 1'b0},
              {58'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        check("reset_result", 64'(bus.result), 64'd0);
        rst = 1'b0;

        // Reset with a MUL in flight
        @(negedge clk);
        bus.start = 1'b1; bus.alu_ctrl = OP_MUL; bus.src1 = 32'd7; bus.src2 = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("rstmul_busy", 64'(bus.busy), 64'd1);
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("rstmul_state", {60'd0, bus.busy, bus.done, bus.zero, bus.overflow}, {60'd0, 4'b0010});
        check("rstmul_result", 64'(bus.result), 64'd0);
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("rstmul_no_done", 64'(dones), 64'd0);

        // Directed cases
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, "add_ovf", 1'b0);
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, "add_carry", 1'b0);
        run_op(OP_SUB, 32'd5, 32'd5, "sub_eq", 1'b0);
        run_op(OP_SLT, 32'h8000_0000, 32'h1, "slt_neg", 1'b0);
        run_op(OP_SLT, 32'h1, 32'h8000_0000, "slt_pos", 1'b0);
        run_op(OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, "slt_ovf", 1'b0);
        run_op(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "and", 1'b0);
        run_op(OP_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, "or", 1'b0);
        run_op(OP_NOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, "nor", 1'b0);
        check("mul_ref_const", 64'(exp_res), 64'h000F_000F);
        run_op(OP_MUL, 32'd12345, 32'd6789, "mul_small", 1'b0);
        check("mul_value", 64'(bus.result), 64'd83810205);
        run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, "mul_ovf", 1'b0);
        run_op(OP_MUL, 32'd12345, 32'd6789, "mul_poke", 1'b1);
        run_op(4'b1111, 32'h1234, 32'h5678, "illegal", 1'b0);

        // Back-to-back single-cycle ops keep done high
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] r;
            logic        co, ov;
            c = (i == 1) ? OP_OR : OP_ADD;
            a = $urandom; b = $urandom;
            bus.alu_ctrl = c; bus.src1 = a; bus.src2 = b;
            model(c, a, b, r, co, ov);
            @(posedge clk); #1;
            check("b2b_done", 64'(bus.done), 64'd1);
            check("b2b_result", {31'd0, bus.result, bus.cout}, {31'd0, r, co});
            exp_res = r; exp_zero = (r == 0); exp_cout = co; exp_ovf = ov;
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("b2b_end", 64'(bus.done), 64'd0);

        // Randomized ops
        for (int i = 0; i < 60; i++) begin
            c = ops[$urandom_range(0, 7)];
            if (c == 4'b1111) c = bad[$urandom_range(0, 8)];
            run_op(c, pick_operand(), pick_operand(), "rand", 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- WIDTH-bit registered ALU built from the 1-bit slice function set (AND/OR/ADD/SUB/NOR/SLT) plus a multi-cycle unsigned shift-add multiply.
- Sits between the register-file read stage and writeback of the lab CPU datapath.
- Uses a start/done handshake so the controller can stall on multi-cycle ops.
- All results and flags are registered.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, multiply step counter width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- alu_ctrl  input  4  op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MUL; others illegal.
- src1  input  WIDTH  operand A.
- src2  input  WIDTH  operand B.
- busy  output  1  high while MUL in progress.
- done  output  1  one-cycle pulse; result/flags valid and held until next done.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0, registered with result.
- cout  output  1  carry out of MSB (ADD/SUB only).
- overflow  output  1  signed overflow (ADD/SUB), product upper half nonzero (MUL).

Behaviour:
- Reset: clk and rst are fixed as above; reset is synchronous and active-high and has priority over everything. On reset: state=IDLE, busy=0, done=0, result=0, zero=1, cout=0, overflow=0. An in-flight MUL is aborted and its partial product discarded.
- FSM states: IDLE, MUL.
- IDLE, start=0: hold outputs; done=0.
- IDLE, start=1, single-cycle op:
  - Operands evaluated at this edge; result and flags updated at the same edge.
  - done=1 for exactly the next cycle; latency 1.
  - Stay in IDLE.
- IDLE, start=1, MUL:
  - Latch src1/src2; clear the 2*WIDTH-bit accumulator; counter=WIDTH; busy=1; go to MUL.
  - result/flags keep their previous values until completion.
- MUL step, one bit per edge, LSB-first:
  - If multiplier bit = 1, add the shifted multiplicand into the accumulator.
  - Decrement the counter.
  - On the edge where the counter goes 1->0: result = low WIDTH bits, overflow = |high WIDTH bits, cout=0, zero updated, busy=0, done=1 next cycle, return to IDLE.
  - Total: done high in cycle WIDTH after the start edge.
- start while busy: ignored. No queueing; operand changes during MUL have no effect.
- start in the done cycle: accepted (state is IDLE), giving back-to-back single-cycle ops with done high continuously.
- ADD: {cout,result} = A+B; overflow = (A[msb]==B[msb]) & (result[msb]!=A[msb]).
- SUB: A + ~B + 1; cout = that carry (1 means no borrow); overflow = (A[msb]!=B[msb]) & (result[msb]!=A[msb]).
- SLT: result = {WIDTH-1 zeros, sign(A-B) XOR overflow(A-B)}, a signed compare correct across overflow; cout=0, overflow=0.
- AND/OR/NOR: bitwise; cout=0, overflow=0.
- Illegal alu_ctrl: result=0, zero=1, cout=0, overflow=0; done pulses with latency 1.
- zero is always computed from the value being written into result.

Test Plan:
- Reset with MUL in flight: src1=7, src2=9, MUL start; assert rst at cycle 5 -> next cycle busy=0, done=0, result=0, zero=1; no done pulse afterwards.
- ADD overflow/carry (WIDTH=32):
  - 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, cout=0, done 1 cycle after start.
  - 0xFFFFFFFF+1 -> result 0, zero=1, cout=1, overflow=0.
- SUB/SLT signed: SUB 5-5 -> zero=1, cout=1. SLT 0x80000000 vs 1 -> result 1. SLT 1 vs 0x80000000 -> 0. SLT 0x7FFFFFFF vs 0x80000000 -> 0.
- Logic ops: src1=0xF0F0F0F0, src2=0x0FF00FF0 -> AND 0x00F000F0, OR 0xFFF0FFF0, NOR 0x000F000F; cout=overflow=0.
- MUL latency/overflow: 12345*6789 -> busy for 32 cycles, done at cycle 32, result 83810205 (0x04FED79D), overflow=0. Then 0x10000*0x10000 -> result 0, zero=1, overflow=1.
- Handshake: start pulsed with SUB during MUL busy -> ignored, result unchanged until MUL done. Back-to-back ADD,OR,ADD on consecutive cycles -> done held high 3 cycles with the matching results; alu_ctrl=1111 -> result 0, done pulse.
